// File: rtl/apple2_disk_pkg.sv
// apple2_disk_pkg: shared constants, scheduler state encoding and the
// track-to-LBA helper used by the NIB track-load scheduler.
package apple2_disk_pkg;

    localparam int NIB_SECS    = 13;
    localparam int NIB_TRACK_W = 6;
    localparam int NIB_DRIVES  = 2;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        WB,
        DONE_WB,
        RD,
        FIN
    } sched_state_t;

    // Track number times 13 as a shift-add, so no multiplier is needed.
    function automatic logic [31:0] lba_x13(input logic [31:0] t);
        return (t << 3) + (t << 2) + t;
    endfunction

endpackage

// File: rtl/sd_burst_seq.sv
// sd_burst_seq: runs one SECS-block transfer on the SD block channel.
// The request level rises on start, stays high across all blocks and drops
// on the ack rise of the last block; the burst ends on that block's ack fall.
module sd_burst_seq
    import apple2_disk_pkg::*;
#(
    parameter int SECS = NIB_SECS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        wr_i,
    input  logic [31:0] base_lba_i,
    input  logic        ack_i,
    output logic        req_o,
    output logic        wr_o,
    output logic [31:0] lba_o,
    output logic [3:0]  buf_sec_o,
    output logic        done_o
);

    localparam logic [3:0] LAST_SEC = 4'(SECS - 1);

    logic        active_q;
    logic        req_q;
    logic        wr_q;
    logic        ack_q;
    logic [31:0] lba_q;
    logic [3:0]  sec_q;
    logic        ack_rise;
    logic        ack_fall;

    assign ack_rise = active_q & ack_i & ~ack_q;
    assign ack_fall = active_q & ~ack_i & ack_q;

    // Burst ends on the fall that follows the dropped request.
    assign done_o    = ack_fall & ~req_q;
    assign req_o     = req_q;
    assign wr_o      = wr_q;
    assign lba_o     = lba_q;
    assign buf_sec_o = sec_q;

    // Block counting: address advances on ack rise, buffer index on ack fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            ack_q    <= 1'b0;
            lba_q    <= '0;
            sec_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            ack_q <= ack_i;
            if (start_i) begin
                active_q <= 1'b1;
                req_q    <= 1'b1;
                wr_q     <= wr_i;
                lba_q    <= base_lba_i;
                sec_q    <= '0;
            end else begin
                if (ack_rise) begin
                    lba_q <= lba_q + 32'd1;
                    if (sec_q == LAST_SEC) begin
                        req_q <= 1'b0;
                    end
                end
                // The final fall leaves buf_sec on the last block so the
                // track RAM address never leaves the track.
                if (ack_fall) begin
                    if (req_q) begin
                        sec_q <= sec_q + 4'd1;
                    end else begin
                        active_q <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/nib_track_sched.sv
// nib_track_sched: arbitrates the single SD block channel between the two
// emulated Disk II drives and loads (and optionally flushes) whole NIB tracks.
// Write-back of dirty track buffers is built only when NIB_WRITEBACK_EN is
// defined; otherwise the block is read-only.
module nib_track_sched
    import apple2_disk_pkg::*;
#(
    parameter int SECS    = NIB_SECS,
    parameter int TRACK_W = NIB_TRACK_W
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic [2*TRACK_W-1:0] track,
    input  logic [1:0]           img_mounted,
    input  logic [1:0]           img_present,
    input  logic [1:0]           dirty,
    output logic [1:0]           dirty_clr,
    output logic [31:0]          sd_lba,
    output logic [1:0]           sd_rd,
    output logic [1:0]           sd_wr,
    input  logic [1:0]           sd_ack,
    output logic                 buf_drive,
    output logic [3:0]           buf_sec,
    output logic                 cpu_wait,
    output logic                 busy
);

    sched_state_t          state_q;
    logic                  drv_q;
    logic                  last_q;
    logic                  busy_q;
    logic [TRACK_W-1:0]    tgt_q;
    logic [TRACK_W-1:0]    res_track_q [NIB_DRIVES];
    logic [1:0]            res_valid_q;
    logic [1:0]            mnt_pend_q;

    logic [TRACK_W-1:0]    trk [NIB_DRIVES];
    logic [1:0]            pend;
    logic                  sel_drv;
    logic                  wb_go;
    logic                  burst_start;
    logic                  burst_wr_d;
    logic [TRACK_W-1:0]    lba_track;
    logic [31:0]           base_lba;
    logic                  burst_req;
    logic                  burst_wr;
    logic                  burst_done;
    logic [1:0]            drv_vec;

    function automatic logic [31:0] track_lba(input logic [TRACK_W-1:0] t);
        logic [31:0] t32;
        t32 = {{(32-TRACK_W){1'b0}}, t};
        if (SECS == 13) begin
            return lba_x13(t32);
        end
        return t32 * 32'(SECS);
    endfunction

    // Per-drive pending: image present and its buffer not holding the wanted track.
    always_comb begin
        for (int d = 0; d < NIB_DRIVES; d++) begin
            trk[d]  = track[d*TRACK_W +: TRACK_W];
            pend[d] = img_present[d] &
                      (mnt_pend_q[d] | ~res_valid_q[d] | (trk[d] != res_track_q[d]));
        end
    end

    // Round-robin: on contention favour the drive not served last.
    assign sel_drv = (pend == 2'b11) ? ~last_q : pend[1];
    assign drv_vec = drv_q ? 2'b10 : 2'b01;

`ifdef NIB_WRITEBACK_EN
    // A fresh mount discards the old buffer, so it is never written back.
    assign wb_go = dirty[drv_q] & res_valid_q[drv_q] & ~mnt_pend_q[drv_q];
`else
    assign wb_go = 1'b0;
    logic unused_dirty;
    assign unused_dirty = ^dirty;
`endif

    // Burst launch: write-back or read from GRANT, the follow-up read from DONE_WB.
    always_comb begin
        // NOTE: defaults first so no path leaves these unassigned and infers a latch.
        burst_start = 1'b0;
        burst_wr_d  = 1'b0;
        lba_track   = tgt_q;
        if (state_q == GRANT && img_present[drv_q]) begin
            burst_start = 1'b1;
            burst_wr_d  = wb_go;
            lba_track   = wb_go ? res_track_q[drv_q] : trk[drv_q];
        end else if (state_q == DONE_WB) begin
            burst_start = 1'b1;
        end
    end

    assign base_lba = track_lba(lba_track);

    sd_burst_seq #(
        .SECS(SECS)
    ) u_burst (
        .clk        (clk_sys),
        .rst_n      (reset_n),
        .start_i    (burst_start),
        .wr_i       (burst_wr_d),
        .base_lba_i (base_lba),
        .ack_i      (sd_ack[drv_q]),
        .req_o      (burst_req),
        .wr_o       (burst_wr),
        .lba_o      (sd_lba),
        .buf_sec_o  (buf_sec),
        .done_o     (burst_done)
    );

    // Scheduler FSM: grant, optional write-back, read, then commit in FIN.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            drv_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            tgt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|pend) begin
                        drv_q   <= sel_drv;
                        last_q  <= sel_drv;
                        busy_q  <= 1'b1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (!img_present[drv_q]) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        tgt_q   <= trk[drv_q];
                        state_q <= wb_go ? WB : RD;
                    end
                end
`ifdef NIB_WRITEBACK_EN
                WB: begin
                    if (burst_done) begin
                        state_q <= DONE_WB;
                    end
                end
                DONE_WB: begin
                    state_q <= RD;
                end
`endif
                RD: begin
                    if (burst_done) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Per-drive residency and mount tracking; later assignments take priority.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: only two small per-drive registers, not a RAM, so resetting them is cheap and required.
            for (int d = 0; d < NIB_DRIVES; d++) begin
                res_track_q[d] <= '0;
            end
            res_valid_q <= '0;
            mnt_pend_q  <= '0;
        end else begin
            for (int d = 0; d < NIB_DRIVES; d++) begin
                if (state_q == GRANT && drv_q == 1'(d)) begin
                    mnt_pend_q[d] <= 1'b0;
                end
                if (img_mounted[d]) begin
                    mnt_pend_q[d] <= 1'b1;
                end
                if (state_q == FIN && drv_q == 1'(d)) begin
                    res_track_q[d] <= tgt_q;
                    res_valid_q[d] <= 1'b1;
                end
                if (!img_present[d]) begin
                    mnt_pend_q[d]  <= 1'b0;
                    res_valid_q[d] <= 1'b0;
                end
            end
        end
    end

`ifdef NIB_WRITEBACK_EN
    logic [1:0] dirty_clr_q;

    // One-cycle write-back completion pulse, high while in DONE_WB.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dirty_clr_q <= '0;
        end else begin
            dirty_clr_q <= (state_q == WB && burst_done) ? drv_vec : 2'b00;
        end
    end

    assign dirty_clr = dirty_clr_q;
    assign sd_wr     = (burst_req & burst_wr) ? drv_vec : 2'b00;
`else
    assign dirty_clr = 2'b00;
    assign sd_wr     = 2'b00;
`endif

    assign sd_rd     = (burst_req & ~burst_wr) ? drv_vec : 2'b00;
    assign buf_drive = drv_q;
    assign cpu_wait  = busy_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_nib_track_sched.sv
// tb_nib_track_sched: directed scenarios for the NIB track-load scheduler.
// Expected SD blocks are queued by the stimulus and compared by a separate
// monitor each time the SD model acknowledges a block.
module tb_nib_track_sched;
    import apple2_disk_pkg::*;

    typedef struct packed {
        logic        drv;
        logic        wr;
        logic [31:0] lba;
        logic [3:0]  sec;
    } blk_t;

`ifdef NIB_WRITEBACK_EN
    localparam int EXP_DC = 1;
`else
    localparam int EXP_DC = 0;
`endif

    logic        clk_sys;
    logic        reset_n;
    logic [11:0] track;
    logic [1:0]  img_mounted;
    logic [1:0]  img_present;
    logic [1:0]  dirty;
    logic [1:0]  dirty_clr;
    logic [31:0] sd_lba;
    logic [1:0]  sd_rd;
    logic [1:0]  sd_wr;
    logic [1:0]  sd_ack;
    logic        buf_drive;
    logic [3:0]  buf_sec;
    logic        cpu_wait;
    logic        busy;

    blk_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   blk_seen = 0;
    int   cyc      = 0;
    int   fall_cyc = 0;
    int   idle_cyc = 0;
    int   dc0_cnt  = 0;

    nib_track_sched dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .track       (track),
        .img_mounted (img_mounted),
        .img_present (img_present),
        .dirty       (dirty),
        .dirty_clr   (dirty_clr),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_ack      (sd_ack),
        .buf_drive   (buf_drive),
        .buf_sec     (buf_sec),
        .cpu_wait    (cpu_wait),
        .busy        (busy)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_blocks(input logic drv, input logic wr, input int base, input int n);
        blk_t b;
        for (int i = 0; i < n; i++) begin
            b.drv = drv;
            b.wr  = wr;
            b.lba = 32'(base + i);
            b.sec = 4'(i);
            exp_q.push_back(b);
        end
    endtask

    task automatic set_track(input int d, input logic [5:0] v);
        track[d*6 +: 6] = v;
    endtask

    task automatic wait_blocks(input int n, input string name);
        int c = 0;
        while (blk_seen < n && c < 2000) begin
            @(negedge clk_sys);
            c++;
        end
        check({name, "_reached"}, 64'(blk_seen >= n), 64'd1);
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while ((exp_q.size() != 0 || busy) && c < 3000) begin
            @(negedge clk_sys);
            c++;
        end
        @(negedge clk_sys);
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_idle"}, 64'(busy), 64'd0);
        check({name, "_fin_latency"}, 64'(idle_cyc - fall_cyc), 64'd2);
    endtask

    // SD model: one-cycle ack per block while a request is raised, one-cycle gap.
    initial begin
        int gap = 0;
        sd_ack = 2'b00;
        forever begin
            @(posedge clk_sys);
            #1;
            if (sd_ack != 2'b00) begin
                sd_ack = 2'b00;
                gap    = 1;
            end else if (gap > 0) begin
                gap--;
            end else if ((sd_rd | sd_wr) != 2'b00) begin
                sd_ack = sd_rd | sd_wr;
            end
        end
    end

    // Event timing: last ack fall, busy fall, dirty_clr high cycles.
    initial begin
        logic ack_p  = 1'b0;
        logic busy_p = 1'b0;
        forever begin
            @(negedge clk_sys);
            cyc++;
            if (ack_p && sd_ack == 2'b00) fall_cyc = cyc;
            if (busy_p && !busy) idle_cyc = cyc;
            if (dirty_clr[0]) dc0_cnt++;
            ack_p  = (sd_ack != 2'b00);
            busy_p = busy;
        end
    end

    // Monitor: every acknowledged block is compared against the queue head.
    initial begin
        logic       ack_prev = 1'b0;
        blk_t       e;
        logic [1:0] v;
        forever begin
            @(negedge clk_sys);
            if (sd_ack != 2'b00 && !ack_prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_block: got lba %0d rd %b wr %b, expected no block",
                             sd_lba, sd_rd, sd_wr);
                end else begin
                    e = exp_q.pop_front();
                    v = e.drv ? 2'b10 : 2'b01;
                    check("block",
                          {21'd0, sd_wr, sd_rd, buf_drive, cpu_wait, busy, buf_sec, sd_lba},
                          {21'd0, e.wr ? v : 2'b00, e.wr ? 2'b00 : v, e.drv, 1'b1, 1'b1, e.sec, e.lba});
                    blk_seen++;
                    @(negedge clk_sys);
                    if (reset_n) begin
                        check("req_after_ack", 64'(sd_rd | sd_wr), 64'((e.sec == 4'd12) ? 2'b00 : v));
                    end
                end
            end
            ack_prev = (sd_ack != 2'b00);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        int dc_base;
        reset_n     = 1'b0;
        track       = '0;
        img_mounted = 2'b00;
        img_present = 2'b00;
        dirty       = 2'b00;
        repeat (3) @(negedge clk_sys);

        check("rst_sd_rd", 64'(sd_rd), 64'd0);
        check("rst_sd_wr", 64'(sd_wr), 64'd0);
        check("rst_sd_lba", 64'(sd_lba), 64'd0);
        check("rst_buf_sec", 64'(buf_sec), 64'd0);
        check("rst_cpu_wait", 64'(cpu_wait), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_dirty_clr", 64'(dirty_clr), 64'd0);
        check("rst_buf_drive", 64'(buf_drive), 64'd0);

        @(posedge clk_sys); #1;
        reset_n = 1'b1;

        // S1: first load of drive 0, track 0 -> LBA 0..12.
        push_blocks(1'b0, 1'b0, 0, 13);
        @(posedge clk_sys); #1;
        img_present = 2'b01;
        @(negedge clk_sys);
        check("s1_busy_before_grant", 64'(busy), 64'd0);
        @(negedge clk_sys);
        check("s1_grant_cycle", 64'({busy, cpu_wait, sd_rd}), 64'b1100);
        @(negedge clk_sys);
        check("s1_req_rise", 64'(sd_rd), 64'b01);
        wait_done("s1");

        // S2: drive 0 track 0 -> 5, reload at LBA 65..77, then stays resident.
        push_blocks(1'b0, 1'b0, 65, 13);
        @(posedge clk_sys); #1;
        set_track(0, 6'd5);
        wait_done("s2");
        repeat (10) @(negedge clk_sys);
        check("s2_no_reload", 64'(busy), 64'd0);

        // S3: drive 0 remount and drive 1 insert contend; drive 1 first (0 served last).
        push_blocks(1'b1, 1'b0, 39, 13);
        push_blocks(1'b0, 1'b0, 65, 13);
        @(posedge clk_sys); #1;
        img_mounted = 2'b01;
        @(posedge clk_sys); #1;
        img_mounted = 2'b00;
        img_present = 2'b11;
        set_track(1, 6'd3);
        wait_done("s3");

        // S4: dirty drive 0, track 5 -> 6: optional write-back at 65, read at 78.
`ifdef NIB_WRITEBACK_EN
        push_blocks(1'b0, 1'b1, 65, 13);
`endif
        push_blocks(1'b0, 1'b0, 78, 13);
        dc_base = dc0_cnt;
        @(posedge clk_sys); #1;
        dirty = 2'b01;
        set_track(0, 6'd6);
        wait_done("s4");
        dirty = 2'b00;
        check("s4_dirty_clr_cycles", 64'(dc0_cnt - dc_base), 64'(EXP_DC));

        // S5: remount reloads 6; track moves to 7 on the 4th ack -> 6 completes, then 91.
        push_blocks(1'b0, 1'b0, 78, 13);
        push_blocks(1'b0, 1'b0, 91, 13);
        n0 = blk_seen;
        @(posedge clk_sys); #1;
        img_mounted = 2'b01;
        @(posedge clk_sys); #1;
        img_mounted = 2'b00;
        wait_blocks(n0 + 4, "s5_4th_ack");
        set_track(0, 6'd7);
        wait_done("s5");

        // S6: drive 1 track 3 -> 2, reset during the 6th block; both drives reload.
        push_blocks(1'b1, 1'b0, 26, 6);
        n0 = blk_seen;
        @(posedge clk_sys); #1;
        set_track(1, 6'd2);
        wait_blocks(n0 + 6, "s6_6th_ack");
        #1;
        reset_n = 1'b0;
        #1;
        check("s6_rst_sd_rd", 64'(sd_rd), 64'd0);
        check("s6_rst_sd_lba", 64'(sd_lba), 64'd0);
        check("s6_rst_buf_sec", 64'(buf_sec), 64'd0);
        check("s6_rst_cpu_wait", 64'(cpu_wait), 64'd0);
        check("s6_rst_busy", 64'(busy), 64'd0);
        check("s6_rst_buf_drive", 64'(buf_drive), 64'd0);
        check("s6_rst_queue", 64'(exp_q.size()), 64'd0);
        push_blocks(1'b1, 1'b0, 26, 13);
        push_blocks(1'b0, 1'b0, 91, 13);
        repeat (3) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        wait_done("s6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
